vred_sequencer: RTL and testbench

Sequencing controller for the vector reduction datapath (`vRedSum_min_max_unit_block`). It accepts a reduction command (op, SEW, beat count, scalar seed), then streams source beats through the unit lane-wise. It folds the surviving lanes in log2 steps and merges the scalar seed. It returns one scalar element with a valid/ready handshake. It sits between the vALU issue logic and the reduction unit and owns the unit exclusively.

---
 rtl/vred_sequencer_pkg.sv | 26 ++
 rtl/vred_sequencer_if.sv | 33 +++
 rtl/vred_sequencer_unit.sv | 56 +++++
 rtl/vred_sequencer.sv | 168 ++++++++++++++++
 tb/tb_vred_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vred_sequencer_pkg.sv
// Shared vALU reduction definitions: op encodings, sequencer states, and a fold-depth helper.
package vred_sequencer_pkg;

  localparam logic [1:0] OpSum = 2'b00;
  localparam logic [1:0] OpMin = 2'b10;
  localparam logic [1:0] OpMax = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StFold,
    StFinal,
    StDone
  } state_e;

  // log2 of the number of SEW lanes in a beat of the given width
  function automatic logic [2:0] lanes_log2(input logic [1:0] sew, input int unsigned width);
    int unsigned lanes;
    lanes = width >> (32'd3 + 32'(sew));
    lanes_log2 = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if ((lanes >> i) != 0) lanes_log2 = 3'(i);
    end
  endfunction

endpackage

// File: rtl/vred_sequencer_if.sv
// Command, source-beat and result handshakes between vALU issue logic and the reduction sequencer.
interface vred_sequencer_if #(
  parameter int unsigned REQ_DATA_WIDTH = 32,
  parameter int unsigned SEW_WIDTH      = 2,
  parameter int unsigned OPSEL_WIDTH    = 2,
  parameter int unsigned CNT_WIDTH      = 6
);
  logic                      start_valid;
  logic                      start_ready;
  logic [SEW_WIDTH-1:0]      start_sew;
  logic [OPSEL_WIDTH-1:0]    start_opsel;
  logic [CNT_WIDTH-1:0]      start_nbeats;
  logic [REQ_DATA_WIDTH-1:0] start_scalar;
  logic                      beat_valid;
  logic                      beat_ready;
  logic [REQ_DATA_WIDTH-1:0] beat_data;
  logic                      res_valid;
  logic                      res_ready;
  logic [REQ_DATA_WIDTH-1:0] res_data;
  logic                      res_err;

  modport master (
    output start_valid, start_sew, start_opsel, start_nbeats, start_scalar,
    output beat_valid, beat_data, res_ready,
    input  start_ready, beat_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  start_valid, start_sew, start_opsel, start_nbeats, start_scalar,
    input  beat_valid, beat_data, res_ready,
    output start_ready, beat_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/vred_sequencer_unit.sv
// Lane-wise reduction unit: registered sum / signed min / signed max of the two halves of vec0,
// or a plain load of the low half when en=0. One-cycle latency.
module vRedSum_min_max_unit_block
  import vred_sequencer_pkg::*;
#(
  parameter int unsigned REQ_DATA_WIDTH = 32,
  parameter int unsigned SEW_WIDTH      = 2,
  parameter int unsigned OPSEL_WIDTH    = 2,
  parameter bit          MIN_MAX_ENABLE = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [SEW_WIDTH-1:0]        sew,
  input  logic [OPSEL_WIDTH-1:0]      opsel,
  input  logic [2*REQ_DATA_WIDTH-1:0] vec0,
  output logic [REQ_DATA_WIDTH-1:0]   vec_out
);
  localparam int unsigned W = REQ_DATA_WIDTH;

  logic [3:0][W-1:0] lane_res;
  logic [W-1:0]      out_q, out_d;
  logic              do_min, do_max;

  assign do_min = MIN_MAX_ENABLE && (opsel == OpMin);
  assign do_max = MIN_MAX_ENABLE && (opsel == OpMax);

  for (genvar s = 0; s < 4; s++) begin : g_sew
    localparam int unsigned EW = 8 << s;
    if (EW <= W) begin : g_on
      for (genvar l = 0; l < W / EW; l++) begin : g_lane
        logic signed [EW-1:0] a, b;
        logic                 lt;
        assign a  = vec0[l*EW +: EW];
        assign b  = vec0[W + l*EW +: EW];
        assign lt = a < b;
        assign lane_res[s][l*EW +: EW] = do_min ? (lt ? a : b) :
                                         do_max ? (lt ? b : a) : a + b;
      end
    end else begin : g_off
      assign lane_res[s] = '0;
    end
  end

  always_comb begin
    out_d = en ? lane_res[sew] : vec0[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign vec_out = out_q;

endmodule

// File: rtl/vred_sequencer.sv
// Reduction sequencer: streams beats into the unit, folds lanes in log2 steps, merges the scalar
// seed and returns one element.
module vred_sequencer
  import vred_sequencer_pkg::*;
#(
  parameter int unsigned REQ_DATA_WIDTH = 32,
  parameter int unsigned SEW_WIDTH      = 2,
  parameter int unsigned OPSEL_WIDTH    = 2,
  parameter int unsigned CNT_WIDTH      = 6
) (
  input logic            clk,
  input logic            rst,
  input logic            flush,
  vred_sequencer_if.slave bus
);
  localparam int unsigned W = REQ_DATA_WIDTH;

  state_e                 state_q, state_d;
  logic [SEW_WIDTH-1:0]   sew_q, sew_d;
  logic [OPSEL_WIDTH-1:0] opsel_q, opsel_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [W-1:0]           scalar_q, scalar_d;
  logic [2:0]             fold_q, fold_d, nfold_q, nfold_d;
  logic                   first_q, first_d, seed_q, seed_d, err_q, err_d;

  logic         unit_en;
  logic [2*W-1:0] unit_vec0;
  logic [W-1:0] unit_out, elem_mask;
  logic [2:0]   fold_k;
  logic         too_wide;

  assign fold_k   = fold_q + 3'd1;
  assign too_wide = (32'd8 << bus.start_sew) > 32'(W);

  always_comb begin
    elem_mask = '0;
    for (int unsigned i = 0; i < W; i++) elem_mask[i] = (i < (32'd8 << sew_q));
  end

  always_comb begin
    state_d  = state_q;
    sew_d    = sew_q;
    opsel_d  = opsel_q;
    cnt_d    = cnt_q;
    scalar_d = scalar_q;
    fold_d   = fold_q;
    nfold_d  = nfold_q;
    first_d  = first_q;
    seed_d   = seed_q;
    err_d    = err_q;
    unit_en   = 1'b0;
    unit_vec0 = {{W{1'b0}}, unit_out};
    bus.start_ready = 1'b0;
    bus.beat_ready  = 1'b0;
    bus.res_valid   = 1'b0;
    bus.res_data    = '0;
    bus.res_err     = 1'b0;

    case (state_q)
      StIdle: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) begin
          sew_d    = bus.start_sew;
          opsel_d  = bus.start_opsel;
          cnt_d    = bus.start_nbeats;
          scalar_d = bus.start_scalar;
          nfold_d  = lanes_log2(bus.start_sew, W);
          fold_d   = '0;
          first_d  = 1'b1;
          if (too_wide) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (bus.start_nbeats == '0) begin
            // Empty vector: FINAL only loads the seed so the result is the scalar itself
            seed_d  = 1'b1;
            state_d = StFinal;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        bus.beat_ready = 1'b1;
        if (bus.beat_valid) begin
          unit_en   = !first_q;
          unit_vec0 = {bus.beat_data, first_q ? bus.beat_data : unit_out};
          first_d   = 1'b0;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == CNT_WIDTH'(1)) state_d = (nfold_q == 3'd0) ? StFinal : StFold;
        end
      end
      StFold: begin
        unit_en   = 1'b1;
        unit_vec0 = {unit_out >> (W >> fold_k), unit_out};
        fold_d    = fold_k;
        if (fold_k == nfold_q) state_d = StFinal;
      end
      StFinal: begin
        if (seed_q) begin
          unit_vec0 = {{W{1'b0}}, scalar_q};
        end else begin
          unit_en   = 1'b1;
          unit_vec0 = {scalar_q, unit_out};
        end
        state_d = StDone;
      end
      StDone: begin
        bus.res_valid = 1'b1;
        bus.res_err   = err_q;
        bus.res_data  = err_q ? '0 : (unit_out & elem_mask);
        if (bus.res_ready) begin
          state_d = StIdle;
          err_d   = 1'b0;
          seed_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d = StIdle;
      err_d   = 1'b0;
      seed_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sew_q    <= '0;
      opsel_q  <= '0;
      cnt_q    <= '0;
      scalar_q <= '0;
      fold_q   <= '0;
      nfold_q  <= '0;
      first_q  <= 1'b0;
      seed_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sew_q    <= sew_d;
      opsel_q  <= opsel_d;
      cnt_q    <= cnt_d;
      scalar_q <= scalar_d;
      fold_q   <= fold_d;
      nfold_q  <= nfold_d;
      first_q  <= first_d;
      seed_q   <= seed_d;
      err_q    <= err_d;
    end
  end

  vRedSum_min_max_unit_block #(
    .REQ_DATA_WIDTH(W),
    .SEW_WIDTH     (SEW_WIDTH),
    .OPSEL_WIDTH   (OPSEL_WIDTH),
    .MIN_MAX_ENABLE(1'b1)
  ) u_unit (
    .clk    (clk),
    .rst    (rst),
    .en     (unit_en),
    .sew    (sew_q),
    .opsel  (opsel_q),
    .vec0   (unit_vec0),
    .vec_out(unit_out)
  );

endmodule

// File: tb/tb_vred_sequencer.sv
// Bench for vred_sequencer: directed vector table, flush/reset sequences, and randomized commands
// against an element-list reduction model.
module tb_vred_sequencer;
  import vred_sequencer_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  vred_sequencer_if #(.REQ_DATA_WIDTH(W), .SEW_WIDTH(2), .OPSEL_WIDTH(2), .CNT_WIDTH(6)) bus ();

  vred_sequencer #(
    .REQ_DATA_WIDTH(W),
    .SEW_WIDTH     (2),
    .OPSEL_WIDTH   (2),
    .CNT_WIDTH     (6)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] beat_mem [16];

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sew;
    int          nb;
    logic [31:0] scalar;
    logic [31:0] b0;
    logic [31:0] b1;
    int          gap;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reduce the flat list of elements (every lane of every beat plus the seed) by the op's rule
  function automatic void model(input logic [1:0] op, input logic [1:0] sew, input int nb,
                                input logic [31:0] scalar, output logic [31:0] data,
                                output logic err, output int lat);
    int unsigned ew, lanes, l2;
    longint unsigned modv, e;
    longint acc, v;
    ew = 8 << sew;
    if (ew > 32) begin
      data = '0; err = 1'b1; lat = 1;
      return;
    end
    modv  = 64'd1 << ew;
    lanes = 32 / ew;
    l2 = 0;
    while ((1 << l2) < lanes) l2++;
    err = 1'b0;
    lat = (nb == 0) ? 2 : int'(l2) + 2;
    e   = longint'(scalar) % modv;
    acc = (e >= modv / 2) ? longint'(e) - longint'(modv) : longint'(e);
    for (int b = 0; b < nb; b++) begin
      for (int unsigned l = 0; l < lanes; l++) begin
        e = longint'(beat_mem[b] >> (l * ew)) % modv;
        v = (e >= modv / 2) ? longint'(e) - longint'(modv) : longint'(e);
        if (op == OpMin)      acc = (v < acc) ? v : acc;
        else if (op == OpMax) acc = (v > acc) ? v : acc;
        else                  acc = acc + v;
      end
    end
    data = 32'(acc & longint'(modv - 1));
  endfunction

  task automatic start_cmd(input logic [1:0] op, input logic [1:0] sew, input int nb,
                           input logic [31:0] scalar);
    bus.start_valid  = 1'b1;
    bus.start_opsel  = op;
    bus.start_sew    = sew;
    bus.start_nbeats = 6'(nb);
    bus.start_scalar = scalar;
    step();
    bus.start_valid = 1'b0;
  endtask

  // gap < 0 picks a random 0..2 idle cycles before every beat
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [1:0] sew,
                         input int nb, input logic [31:0] scalar, input int gap, input int hold,
                         input bit flush_end, input logic [31:0] exp_data, input logic exp_err,
                         input int exp_lat);
    int cnt;
    int g;
    chk({tag, ".start_ready"}, bus.start_ready, 1);
    start_cmd(op, sew, nb, scalar);
    if (!exp_err) begin
      for (int b = 0; b < nb; b++) begin
        g = (gap < 0) ? int'($urandom_range(2, 0)) : ((b == 0) ? 0 : gap);
        for (int i = 0; i < g; i++) begin
          chk({tag, ".gap_beat_ready"}, bus.beat_ready, 1);
          step();
        end
        bus.beat_valid = 1'b1;
        bus.beat_data  = beat_mem[b];
        chk({tag, ".beat_ready"}, bus.beat_ready, 1);
        step();
        bus.beat_valid = 1'b0;
      end
    end
    cnt = 1;
    while (!bus.res_valid && cnt < 40) begin
      step();
      cnt++;
    end
    chk({tag, ".latency"}, cnt, exp_lat);
    chk({tag, ".res_data"}, bus.res_data, exp_data);
    chk({tag, ".res_err"}, bus.res_err, exp_err);
    for (int h = 0; h < hold; h++) begin
      bus.res_ready = 1'b0;
      step();
      chk({tag, ".hold_valid"}, bus.res_valid, 1);
      chk({tag, ".hold_data"}, bus.res_data, exp_data);
      chk({tag, ".hold_beat_ready"}, bus.beat_ready, 0);
    end
    bus.res_ready = 1'b1;
    if (flush_end) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
      bus.res_ready = 1'b0;
      chk({tag, ".flush_valid"}, bus.res_valid, 0);
      chk({tag, ".flush_start_ready"}, bus.start_ready, 1);
    end else begin
      chk({tag, ".bubble"}, bus.start_ready, 0);
      step();
      bus.res_ready = 1'b0;
      chk({tag, ".released"}, bus.res_valid, 0);
      chk({tag, ".idle_ready"}, bus.start_ready, 1);
    end
  endtask

  task automatic run_vec(input string tag, input int idx, input bit flush_end);
    beat_mem[0] = vecs[idx].b0;
    beat_mem[1] = vecs[idx].b1;
    run_cmd(tag, vecs[idx].op, vecs[idx].sew, vecs[idx].nb, vecs[idx].scalar, vecs[idx].gap,
            vecs[idx].hold, flush_end, vecs[idx].exp_data, vecs[idx].exp_err, vecs[idx].exp_lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op, sew;
    int          nb, lat;
    logic [31:0] scalar, data;
    logic        err;

    vecs[0] = '{OpSum, 2'd0, 2, 32'h05, 32'h0102_0304, 32'h1010_1010, 0, 0, 32'h4F, 1'b0, 4};
    vecs[1] = '{OpSum, 2'd0, 1, 32'h01, 32'hFFFF_FFFF, 32'h0, 0, 0, 32'hFD, 1'b0, 4};
    vecs[2] = '{OpMin, 2'd2, 2, 32'h07, 32'h9, 32'h3, 1, 0, 32'h3, 1'b0, 2};
    vecs[3] = '{OpSum, 2'd1, 0, 32'h1234_ABCD, 32'h0, 32'h0, 0, 0, 32'hABCD, 1'b0, 2};
    vecs[4] = '{OpSum, 2'd3, 0, 32'h1234_ABCD, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1, 1};
    vecs[5] = '{OpMax, 2'd1, 2, 32'h05, 32'h8000_7000, 32'h0001_0002, 0, 5, 32'h7000, 1'b0, 3};
    vecs[6] = '{OpMin, 2'd0, 1, 32'h80, 32'h7F7F_7F7F, 32'h0, 0, 0, 32'h80, 1'b0, 4};

    rst = 1'b1;
    flush = 1'b0;
    bus.start_valid = 1'b0; bus.start_sew = '0; bus.start_opsel = '0;
    bus.start_nbeats = '0; bus.start_scalar = '0;
    bus.beat_valid = 1'b0; bus.beat_data = '0; bus.res_ready = 1'b0;
    #3;
    chk("reset.start_ready", bus.start_ready, 1);
    chk("reset.beat_ready", bus.beat_ready, 0);
    chk("reset.res_valid", bus.res_valid, 0);
    chk("reset.res_data", bus.res_data, 0);
    chk("reset.res_err", bus.res_err, 0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), i, 1'b0);

    // flush mid-ACCUM together with an offered beat
    start_cmd(OpSum, 2'd0, 3, 32'h0);
    bus.beat_valid = 1'b1;
    bus.beat_data  = 32'h1111_1111;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.beat_valid = 1'b0;
    chk("flush_accum.beat_ready", bus.beat_ready, 0);
    chk("flush_accum.start_ready", bus.start_ready, 1);
    chk("flush_accum.res_valid", bus.res_valid, 0);
    run_vec("after_flush_accum", 0, 1'b0);

    run_vec("flush_done", 1, 1'b1);
    run_vec("after_flush_done", 0, 1'b0);

    // async reset while folding
    start_cmd(OpSum, 2'd0, 1, 32'h0);
    bus.beat_valid = 1'b1;
    bus.beat_data  = 32'h0101_0101;
    step();
    bus.beat_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_fold.start_ready", bus.start_ready, 1);
    chk("rst_fold.beat_ready", bus.beat_ready, 0);
    chk("rst_fold.res_valid", bus.res_valid, 0);
    chk("rst_fold.res_data", bus.res_data, 0);
    chk("rst_fold.res_err", bus.res_err, 0);
    step();
    rst = 1'b0;
    step();
    run_vec("after_rst", 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(2, 0))
        0:       op = OpSum;
        1:       op = OpMin;
        default: op = OpMax;
      endcase
      sew    = 2'($urandom_range(3, 0));
      nb     = int'($urandom_range(5, 0));
      scalar = $urandom;
      for (int b = 0; b < nb; b++) beat_mem[b] = $urandom;
      model(op, sew, nb, scalar, data, err, lat);
      run_cmd($sformatf("rand%0d", n), op, sew, nb, scalar, -1, int'($urandom_range(2, 0)),
              1'b0, data, err, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
